// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out receiver. Rebuilds WIDTH-bit words from a qualified
// serial stream (bit_start marks the first bit of a frame), parks completed
// words in a holding register and hands them downstream on valid/ready.
// Overrun and framing errors are reported as single-cycle registered pulses.
module sipo_deserializer #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_valid,
  input  logic             bit_start,
  input  logic             serial_in,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun,
  output logic             framing_err
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastIdx = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  typedef enum logic [0:0] {StIdle, StRecv} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  sr_q, sr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  hold_q, hold_d;
  logic              out_valid_q, out_valid_d;
  logic              overrun_q, overrun_d;
  logic              framing_err_q, framing_err_d;

  logic [WIDTH-1:0]  sr_shifted;
  logic              complete;

  // Shift register with the current serial bit inserted at the frame-order end.
  always_comb begin
    sr_shifted = sr_q;
    if (MSB_FIRST) begin
      sr_shifted = {sr_q[WIDTH-2:0], serial_in};
    end else begin
      sr_shifted = {serial_in, sr_q[WIDTH-1:1]};
    end
  end

  // Receive FSM: frame tracking, bit counting and framing error detection.
  always_comb begin
    state_d       = state_q;
    sr_d          = sr_q;
    cnt_d         = cnt_q;
    complete      = 1'b0;
    framing_err_d = 1'b0;

    if (bit_valid) begin
      unique case (state_q)
        StIdle: begin
          // Bits without a start marker are dropped while idle.
          if (bit_start) begin
            sr_d    = sr_shifted;
            cnt_d   = CntOne;
            state_d = StRecv;
          end
        end
        StRecv: begin
          sr_d = sr_shifted;
          if (bit_start) begin
            // Restart: the partial frame is abandoned, this bit opens a new one.
            cnt_d         = CntOne;
            framing_err_d = 1'b1;
          end else if (cnt_q == LastIdx) begin
            complete = 1'b1;
            cnt_d    = '0;
            state_d  = StIdle;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Holding register and valid/ready handshake; a completing word always wins.
  always_comb begin
    hold_d      = hold_q;
    out_valid_d = out_valid_q;
    overrun_d   = 1'b0;

    if (complete) begin
      hold_d      = sr_shifted;
      out_valid_d = 1'b1;
      // Only an unconsumed word being replaced counts as an overrun.
      overrun_d   = out_valid_q & ~out_ready;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      sr_q          <= '0;
      cnt_q         <= '0;
      hold_q        <= '0;
      out_valid_q   <= 1'b0;
      overrun_q     <= 1'b0;
      framing_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sr_q          <= sr_d;
      cnt_q         <= cnt_d;
      hold_q        <= hold_d;
      out_valid_q   <= out_valid_d;
      overrun_q     <= overrun_d;
      framing_err_q <= framing_err_d;
    end
  end

  // All outputs come straight from registers.
  always_comb begin
    parallel_out = hold_q;
    out_valid    = out_valid_q;
    busy         = (state_q == StRecv);
    overrun      = overrun_q;
    framing_err  = framing_err_q;
  end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer: a WIDTH=4 MSB-first unit and a WIDTH=8
// LSB-first unit share a clock; both are compared every cycle against a
// frame-level reference model, plus table rows and directed corner cases.
module tb_sipo_deserializer;

  logic       clk;
  logic       rst_n;
  logic       b_valid [2];
  logic       b_start [2];
  logic       s_in    [2];
  logic       o_ready [2];
  logic [3:0] po0;
  logic [7:0] po1;
  logic       ov  [2];
  logic       bsy [2];
  logic       ovr [2];
  logic       ferr[2];

  int checks;
  int errors;

  sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_dut0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .bit_valid   (b_valid[0]),
    .bit_start   (b_start[0]),
    .serial_in   (s_in[0]),
    .parallel_out(po0),
    .out_valid   (ov[0]),
    .out_ready   (o_ready[0]),
    .busy        (bsy[0]),
    .overrun     (ovr[0]),
    .framing_err (ferr[0])
  );

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .bit_valid   (b_valid[1]),
    .bit_start   (b_start[1]),
    .serial_in   (s_in[1]),
    .parallel_out(po1),
    .out_valid   (ov[1]),
    .out_ready   (o_ready[1]),
    .busy        (bsy[1]),
    .overrun     (ovr[1]),
    .framing_err (ferr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: list of bits received in the current frame.
  int          mw   [2] = '{4, 8};
  bit          mmsb [2] = '{1'b1, 1'b0};
  bit          fbits[2][32];
  int          fcnt [2];
  bit          inframe[2];
  logic [31:0] mword[2];
  bit          mvld [2];
  bit          movr [2];
  bit          mferr[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      fcnt[u] = 0; inframe[u] = 0; mword[u] = '0;
      mvld[u] = 0; movr[u] = 0; mferr[u] = 0;
    end
  endtask

  task automatic model_step(input int u, input bit v, input bit s, input bit d, input bit r);
    bit          done;
    logic [31:0] w;
    done     = 0;
    movr[u]  = 0;
    mferr[u] = 0;
    if (v) begin
      if (s) begin
        if (inframe[u]) mferr[u] = 1;
        fcnt[u]    = 0;
        inframe[u] = 1;
      end
      if (inframe[u]) begin
        fbits[u][fcnt[u]] = d;
        fcnt[u]++;
        if (fcnt[u] == mw[u]) begin
          done       = 1;
          inframe[u] = 0;
        end
      end
    end
    if (done) begin
      w = '0;
      // i-th received bit goes to the top (MSB first) or bottom (LSB first).
      for (int i = 0; i < mw[u]; i++) w[mmsb[u] ? (mw[u] - 1 - i) : i] = fbits[u][i];
      fcnt[u]  = 0;
      movr[u]  = mvld[u] && !r;
      mword[u] = w;
      mvld[u]  = 1;
    end else if (mvld[u] && r) begin
      mvld[u] = 0;
    end
  endtask

  task automatic compare_models();
    chk("u0.parallel_out", {28'b0, po0}, mword[0]);
    chk("u0.out_valid",    {31'b0, ov[0]},   {31'b0, mvld[0]});
    chk("u0.busy",         {31'b0, bsy[0]},  {31'b0, inframe[0]});
    chk("u0.overrun",      {31'b0, ovr[0]},  {31'b0, movr[0]});
    chk("u0.framing_err",  {31'b0, ferr[0]}, {31'b0, mferr[0]});
    chk("u1.parallel_out", {24'b0, po1}, mword[1]);
    chk("u1.out_valid",    {31'b0, ov[1]},   {31'b0, mvld[1]});
    chk("u1.busy",         {31'b0, bsy[1]},  {31'b0, inframe[1]});
    chk("u1.overrun",      {31'b0, ovr[1]},  {31'b0, movr[1]});
    chk("u1.framing_err",  {31'b0, ferr[1]}, {31'b0, mferr[1]});
  endtask

  // One clock: drive both units, step the model, sample 1 ns after the edge.
  task automatic tick(input bit v0, input bit s0, input bit d0, input bit r0,
                      input bit v1, input bit s1, input bit d1, input bit r1);
    b_valid[0] = v0; b_start[0] = s0; s_in[0] = d0; o_ready[0] = r0;
    b_valid[1] = v1; b_start[1] = s1; s_in[1] = d1; o_ready[1] = r1;
    @(posedge clk);
    model_step(0, v0, s0, d0, r0);
    model_step(1, v1, s1, d1, r1);
    #1;
    compare_models();
  endtask

  task automatic t0(input bit v, input bit s, input bit d, input bit r);
    tick(v, s, d, r, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic t1(input bit v, input bit s, input bit d, input bit r);
    tick(1'b0, 1'b0, 1'b0, 1'b0, v, s, d, r);
  endtask

  typedef struct {
    bit       v, s, d, r;
    logic [3:0] po;
    bit       ov, busy, ovr, ferr;
  } vec_t;

  vec_t tbl[20];

  initial begin
    checks = 0;
    errors = 0;

    // Frame 1011 back to back, then the same frame with a 2-cycle gap, then a
    // restarted frame ending in 0110, then idle bits without start.
    tbl[0]  = '{1, 1, 1, 1, 4'b0000, 0, 1, 0, 0};
    tbl[1]  = '{1, 0, 0, 1, 4'b0000, 0, 1, 0, 0};
    tbl[2]  = '{1, 0, 1, 1, 4'b0000, 0, 1, 0, 0};
    tbl[3]  = '{1, 0, 1, 1, 4'b1011, 1, 0, 0, 0};
    tbl[4]  = '{0, 0, 0, 1, 4'b1011, 0, 0, 0, 0};
    tbl[5]  = '{1, 1, 1, 1, 4'b1011, 0, 1, 0, 0};
    tbl[6]  = '{1, 0, 0, 1, 4'b1011, 0, 1, 0, 0};
    tbl[7]  = '{0, 0, 1, 1, 4'b1011, 0, 1, 0, 0};
    tbl[8]  = '{0, 0, 0, 1, 4'b1011, 0, 1, 0, 0};
    tbl[9]  = '{1, 0, 1, 1, 4'b1011, 0, 1, 0, 0};
    tbl[10] = '{1, 0, 1, 1, 4'b1011, 1, 0, 0, 0};
    tbl[11] = '{0, 0, 0, 1, 4'b1011, 0, 0, 0, 0};
    tbl[12] = '{1, 1, 1, 1, 4'b1011, 0, 1, 0, 0};
    tbl[13] = '{1, 0, 0, 1, 4'b1011, 0, 1, 0, 0};
    tbl[14] = '{1, 1, 0, 1, 4'b1011, 0, 1, 0, 1};
    tbl[15] = '{1, 0, 1, 1, 4'b1011, 0, 1, 0, 0};
    tbl[16] = '{1, 0, 1, 1, 4'b1011, 0, 1, 0, 0};
    tbl[17] = '{1, 0, 0, 1, 4'b0110, 1, 0, 0, 0};
    tbl[18] = '{1, 0, 1, 1, 4'b0110, 0, 0, 0, 0};
    tbl[19] = '{1, 0, 0, 1, 4'b0110, 0, 0, 0, 0};

    for (int u = 0; u < 2; u++) begin
      b_valid[u] = 0; b_start[u] = 0; s_in[u] = 0; o_ready[u] = 0;
    end
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    compare_models();

    // Table vectors on the 4-bit unit.
    for (int i = 0; i < 20; i++) begin
      t0(tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].r);
      chk($sformatf("tbl[%0d].parallel_out", i), {28'b0, po0}, {28'b0, tbl[i].po});
      chk($sformatf("tbl[%0d].out_valid", i), {31'b0, ov[0]}, {31'b0, tbl[i].ov});
      chk($sformatf("tbl[%0d].busy", i), {31'b0, bsy[0]}, {31'b0, tbl[i].busy});
      chk($sformatf("tbl[%0d].overrun", i), {31'b0, ovr[0]}, {31'b0, tbl[i].ovr});
      chk($sformatf("tbl[%0d].framing_err", i), {31'b0, ferr[0]}, {31'b0, tbl[i].ferr});
    end

    // Overrun: 1100 then 0011 with out_ready low.
    t0(1, 1, 1, 0); t0(1, 0, 1, 0); t0(1, 0, 0, 0); t0(1, 0, 0, 0);
    chk("ovr.first_valid", {31'b0, ov[0]}, 32'd1);
    chk("ovr.first_no_overrun", {31'b0, ovr[0]}, 32'd0);
    t0(1, 1, 0, 0); t0(1, 0, 0, 0); t0(1, 0, 1, 0); t0(1, 0, 1, 0);
    chk("ovr.pulse", {31'b0, ovr[0]}, 32'd1);
    chk("ovr.word", {28'b0, po0}, 32'h3);
    chk("ovr.valid_held", {31'b0, ov[0]}, 32'd1);
    t0(0, 0, 0, 0);
    chk("ovr.pulse_one_cycle", {31'b0, ovr[0]}, 32'd0);
    chk("ovr.valid_still_held", {31'b0, ov[0]}, 32'd1);
    t0(0, 0, 0, 1);
    chk("ovr.valid_falls", {31'b0, ov[0]}, 32'd0);

    // Asynchronous reset mid-frame clears outputs without a clock edge.
    t0(1, 1, 1, 1); t0(1, 0, 0, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst.parallel_out", {28'b0, po0}, 32'h0);
    chk("arst.out_valid", {31'b0, ov[0]}, 32'd0);
    chk("arst.busy", {31'b0, bsy[0]}, 32'd0);
    chk("arst.overrun", {31'b0, ovr[0]}, 32'd0);
    chk("arst.framing_err", {31'b0, ferr[0]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    t0(1, 1, 1, 1); t0(1, 0, 0, 1); t0(1, 0, 0, 1); t0(1, 0, 1, 1);
    chk("arst.next_frame", {28'b0, po0}, 32'h9);
    chk("arst.next_valid", {31'b0, ov[0]}, 32'd1);

    // LSB-first 8-bit unit: 1,0,0,0,0,0,0,1 then a stray 0.
    t1(1, 1, 1, 0);
    for (int i = 0; i < 6; i++) t1(1, 0, 0, 0);
    t1(1, 0, 1, 0);
    chk("lsb.word1", {24'b0, po1}, 32'h81);
    t1(1, 0, 0, 0);
    chk("lsb.stray_ignored", {31'b0, bsy[1]}, 32'd0);
    // 1,1,0,0,0,0,0,0; last bit coincides with out_ready.
    t1(1, 1, 1, 0); t1(1, 0, 1, 0);
    for (int i = 0; i < 5; i++) t1(1, 0, 0, 0);
    chk("lsb.valid_before", {31'b0, ov[1]}, 32'd1);
    t1(1, 0, 0, 1);
    chk("lsb.word2", {24'b0, po1}, 32'h03);
    chk("lsb.valid_continuous", {31'b0, ov[1]}, 32'd1);
    chk("lsb.no_overrun", {31'b0, ovr[1]}, 32'd0);
    t1(0, 0, 0, 1);
    chk("lsb.drained", {31'b0, ov[1]}, 32'd0);

    // Randomized traffic on both units against the model.
    for (int n = 0; n < 3000; n++) begin
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, 1'($urandom),
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 12) == 0, 1'($urandom),
           $urandom_range(0, 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
